// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the data-memory bus
// of the load/store unit.
//   req_*  : core request (valid/ready, we, funct3, address, store data)
//   rsp_*  : one-cycle response strobe with extended load data and error code
//   mem_*  : memory request/ack handshake with word address, byte enables
//            and lane-replicated store data
//   stall_o: unit busy (not idle)
// Modports: slave = the load/store unit; master = core plus memory side.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit placed after the ALU. Accepts one request in IDLE, checks
// funct3 legality and alignment, drives a valid/ack memory request with byte
// enables and replicated store data, and returns a single response with
// sign/zero-extended load data or an error code.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Parameter TIMEOUT_CYCLES: REQ cycles without ack before a timeout error
// (0 disables the timeout).
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;
  logic [1:0]  r_err, w_err_nxt;

  logic        w_accept, w_illegal, w_misaligned, w_timeout, w_in_req, w_in_resp;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data, w_wdata_rep;
  logic [3:0]  w_be;

  assign w_accept  = bus.req_valid_i && (r_state == IDLE);
  assign w_in_req  = (r_state == REQ);
  assign w_in_resp = (r_state == RESP);
  assign w_timeout = LP_TO_EN && (r_cnt == LP_TO_LAST);

  // Legality and alignment are judged on the live request inputs at accept.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (bus.req_we_i)
      w_illegal = bus.req_funct3_i[2] || (bus.req_funct3_i[1:0] == 2'b11);
    else
      w_illegal = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i[2:1] == 2'b11);
    unique case (bus.req_funct3_i[1:0])
      2'b01:   w_misaligned = bus.req_addr_i[0];
      2'b10:   w_misaligned = |bus.req_addr_i[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_state_nxt = RESP;
            w_err_nxt   = 2'b11;
          end else if (w_misaligned) begin
            w_state_nxt = RESP;
            w_err_nxt   = 2'b01;
          end else begin
            w_state_nxt = REQ;
            w_err_nxt   = 2'b00;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack_i) begin
          w_state_nxt = RESP;
          w_err_nxt   = 2'b00;
        end else if (w_timeout) begin
          w_state_nxt = RESP;
          w_err_nxt   = 2'b10;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Load extraction and extension happen at ack time so RESP only replays
  // a register.
  always_comb begin
    unique case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_rdata_i[7:0];
      2'd1:    w_byte = bus.mem_rdata_i[15:8];
      2'd2:    w_byte = bus.mem_rdata_i[23:16];
      default: w_byte = bus.mem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = bus.mem_rdata_i;
    endcase
  end

  always_comb begin
    unique case (r_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = 4'b0011 << r_addr[1:0];
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (w_accept) begin
        r_we     <= bus.req_we_i;
        r_funct3 <= bus.req_funct3_i;
        r_addr   <= bus.req_addr_i;
        r_wdata  <= bus.req_wdata_i;
        r_rdata  <= '0;
        r_cnt    <= '0;
      end
      if (w_in_req) begin
        if (bus.mem_ack_i) r_rdata <= r_we ? '0 : w_load_data;
        else               r_cnt   <= r_cnt + 32'd1;
      end
    end
  end

  assign bus.req_ready_o = (r_state == IDLE);
  assign bus.stall_o     = (r_state != IDLE);
  assign bus.mem_req_o   = w_in_req;
  assign bus.mem_we_o    = w_in_req && r_we;
  assign bus.mem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign bus.mem_be_o    = w_in_req ? w_be : '0;
  assign bus.mem_wdata_o = w_in_req ? w_wdata_rep : '0;
  assign bus.rsp_valid_o = w_in_resp;
  assign bus.rsp_rdata_o = w_in_resp ? r_rdata : '0;
  assign bus.rsp_err_o   = w_in_resp ? r_err : '0;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential stage directly downstream of the ALU. Consumes the ALU result as the effective address for loads and stores.
- Performs alignment checks, byte-enable generation, store-data lane replication and load sign/zero extension.
- Runs a valid/ack handshake to a variable-latency data memory, with a timeout.
- Returns one response per accepted request; the core stalls on stall_o while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ without mem_ack_i before the request is aborted with a timeout error. A value of 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid_i  input  1  core presents a memory operation
- req_ready_o  output  1  unit can accept a request (high only in IDLE)
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RISC-V funct3 (size and signedness)
- req_addr_i  input  32  effective address (ALU result)
- req_wdata_i  input  32  store data (rs2)
- rsp_valid_o  output  1  one-cycle response strobe
- rsp_rdata_o  output  32  extended load data; 0 for stores and errors
- rsp_err_o  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
- mem_req_o  output  1  memory request, held until ack or timeout
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  32  lane-replicated store data
- mem_ack_i  input  1  memory completion; only meaningful while mem_req_o=1
- mem_rdata_i  input  32  read word, valid with mem_ack_i
- stall_o  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - req_ready_o=1 (decoded from IDLE).
  - All other outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - A request is accepted on an edge where req_valid_i & req_ready_o. Accepting latches we, funct3, addr and wdata.
  - Illegal funct3 goes to RESP with err=11. Illegal means: load with 011, 110 or 111; store with funct3[2]=1 or 011.
  - A misaligned access goes to RESP with err=01. Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise the next state is REQ and the counter clears.
  - Error paths never assert mem_req_o.
- REQ outputs:
  - mem_req_o=1, with mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o stable for the whole state.
- REQ byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- REQ store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- REQ exit conditions:
  - mem_ack_i=1: capture mem_rdata_i and go to RESP with err=00.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and no ack (TIMEOUT_CYCLES>0), go to RESP with err=10.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Load data extraction:
  - Byte lane = rdata[8*addr[1:0] +: 8]; half lane = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rsp_rdata_o is 0 for stores and for every error response.
- Latency, accept edge to rsp_valid_o:
  - Error path: 1 cycle.
  - Aligned access acked in the first REQ cycle: 2 cycles.
  - Each extra wait cycle adds 1.
- mem_ack_i outside REQ is ignored.
- req_valid_i while not in IDLE is ignored; the core holds it.
- Reset in REQ or RESP aborts the transaction:
  - mem_req_o=0 and rsp_valid_o=0 after that edge.
  - No response is issued for the aborted request.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after RESP.

Test Plan:
- LB at addr 0x0000_1003, mem_rdata 0x80FF_1234, ack in 1st REQ cycle -> mem_addr 0x0000_1000, mem_be 4'b1000, rsp_rdata 0xFFFF_FF80, err 00, rsp_valid 2 cycles after accept.
- LHU at addr 0x0000_2002, rdata 0xBEEF_0000, ack after 3 wait cycles -> be 4'b1100, rsp_rdata 0x0000_BEEF, mem_req_o high 4 cycles, stall_o high until RESP ends.
- SB at addr 0x0000_0005, wdata 0x1234_56A5 -> mem_we 1, be 4'b0010, mem_wdata 0xA5A5_A5A5, rsp_rdata 0, err 00.
- LW at addr 0x0000_0006 -> no mem_req_o, rsp_valid 1 cycle after accept with err 01. Separately, load funct3=3'b111 -> err 11.
- TIMEOUT_CYCLES=4, mem_ack_i held low -> mem_req_o high exactly 4 cycles, then rsp err 10. Repeat with ack on the 4th cycle -> err 00.
- Reset asserted in the 2nd REQ cycle -> next cycle mem_req_o=0, req_ready_o=1, no rsp_valid. A late mem_ack_i is ignored.
